// File: rtl/cpu_idecode_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : opcodes, ALU op codes, immediate formats and decode helpers
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // RV32I operations occupy 0-15, M-extension operations 16-23
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_PASSB  = 5'd10;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_X = 3'd6
  } imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  alu_op;
    logic        alu_src_imm;
    logic        wb_en;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } dec_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] imm;
    case (fmt)
      FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {ins[31:12], 12'h000};
      FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = 32'h0;
    endcase
    return imm;
  endfunction

  // alt selects SUB/SRA; the caller decides whether alt is legal for funct3
  function automatic logic [4:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [4:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  function automatic logic fmt_has_rd(input imm_fmt_e fmt);
    return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_idecode_if.sv
// ---------------------------------------------------------------------------
// cpu_idecode_if : fetch / write-back inputs and decoded outputs of decode
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface cpu_idecode_if;
  logic        i_otp_rdy;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        e_j_flag;
  logic        d_inp_rdy;
  logic        w_en;
  logic [4:0]  w_rd;
  logic [31:0] w_data;

  logic        d_stall;
  logic        d_otp_rdy;
  logic [31:0] d_pc;
  logic [31:0] d_rs1_val;
  logic [31:0] d_rs2_val;
  logic [31:0] d_imm;
  logic [4:0]  d_rd;
  logic [2:0]  d_funct3;
  logic [4:0]  d_alu_op;
  logic        d_alu_src_imm;
  logic        d_wb_en;
  logic        d_is_load;
  logic        d_is_store;
  logic        d_is_branch;
  logic        d_is_jal;
  logic        d_is_jalr;
  logic        d_illegal;

  modport master (
    output i_otp_rdy, f_instr, f_pc, e_j_flag, d_inp_rdy, w_en, w_rd, w_data,
    input  d_stall, d_otp_rdy, d_pc, d_rs1_val, d_rs2_val, d_imm, d_rd, d_funct3,
           d_alu_op, d_alu_src_imm, d_wb_en, d_is_load, d_is_store, d_is_branch,
           d_is_jal, d_is_jalr, d_illegal
  );

  modport slave (
    input  i_otp_rdy, f_instr, f_pc, e_j_flag, d_inp_rdy, w_en, w_rd, w_data,
    output d_stall, d_otp_rdy, d_pc, d_rs1_val, d_rs2_val, d_imm, d_rd, d_funct3,
           d_alu_op, d_alu_src_imm, d_wb_en, d_is_load, d_is_store, d_is_branch,
           d_is_jal, d_is_jalr, d_illegal
  );
endinterface

`default_nettype wire

// File: rtl/cpu_idecode_regfile.sv
// ---------------------------------------------------------------------------
// cpu_regfile : 32x32 register file, x0 hardwired, write-through bypass
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] mem_q [32];
  logic [31:0] mem_d [32];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != 5'd0)) begin
      mem_d[waddr] = wdata;
    end
    mem_d[0] = 32'h0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      mem_q[i] <= rst ? 32'h0 : mem_d[i];
    end
  end

  // A write in the same cycle as the read is forwarded so decode sees it now
  assign rdata1 = (raddr1 == 5'd0)             ? 32'h0 :
                  (we && (waddr == raddr1))    ? wdata : mem_q[raddr1];
  assign rdata2 = (raddr2 == 5'd0)             ? 32'h0 :
                  (we && (waddr == raddr2))    ? wdata : mem_q[raddr2];

endmodule

`default_nettype wire

// File: rtl/cpu_idecode.sv
// ---------------------------------------------------------------------------
// cpu_idecode : RV32 decode stage with load-use stall and redirect flush.
// Optional RV32M decode enabled by defining CPU_RV32M_EN.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_idecode
  import cpu_pkg::*;
(
  input logic          clk,
  input logic          rst,
  cpu_idecode_if.slave bus
);

  dec_t        dec_q;
  dec_t        dec_d;
  dec_t        dec_new;
  imm_fmt_e    fmt;
  logic        legal;
  logic        wb_req;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        accept;
  logic        stall;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rs1_idx;
  logic [4:0] rs2_idx;
  logic [4:0] rd_idx;

  assign opcode  = bus.f_instr[6:0];
  assign rd_idx  = bus.f_instr[11:7];
  assign funct3  = bus.f_instr[14:12];
  assign rs1_idx = bus.f_instr[19:15];
  assign rs2_idx = bus.f_instr[24:20];
  assign funct7  = bus.f_instr[31:25];

  cpu_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (bus.w_en),
    .waddr  (bus.w_rd),
    .wdata  (bus.w_data),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  always_comb begin
    fmt     = FMT_X;
    legal   = 1'b1;
    wb_req  = 1'b0;
    dec_new = '0;
    dec_new.valid   = 1'b1;
    dec_new.pc      = bus.f_pc;
    dec_new.rs1_val = rs1_val;
    dec_new.rs2_val = rs2_val;
    dec_new.funct3  = funct3;
    dec_new.alu_op  = ALU_ADD;

    case (opcode)
      OPC_LUI: begin
        fmt = FMT_U; wb_req = 1'b1;
        dec_new.alu_op = ALU_PASSB; dec_new.alu_src_imm = 1'b1;
      end
      OPC_AUIPC: begin
        fmt = FMT_U; wb_req = 1'b1; dec_new.alu_src_imm = 1'b1;
      end
      OPC_JAL: begin
        fmt = FMT_J; wb_req = 1'b1; dec_new.alu_src_imm = 1'b1; dec_new.is_jal = 1'b1;
      end
      OPC_JALR: begin
        fmt = FMT_I; wb_req = 1'b1; dec_new.alu_src_imm = 1'b1; dec_new.is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        fmt = FMT_B; dec_new.alu_op = ALU_SUB; dec_new.is_branch = 1'b1;
      end
      OPC_LOAD: begin
        fmt = FMT_I; wb_req = 1'b1; dec_new.alu_src_imm = 1'b1; dec_new.is_load = 1'b1;
      end
      OPC_STORE: begin
        fmt = FMT_S; dec_new.alu_src_imm = 1'b1; dec_new.is_store = 1'b1;
      end
      OPC_OP_IMM: begin
        fmt = FMT_I; wb_req = 1'b1; dec_new.alu_src_imm = 1'b1;
        // Only the shift encodings carry a funct7 field inside the immediate
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_BASE);
          dec_new.alu_op = ALU_SLL;
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          dec_new.alu_op = alu_base(funct3, funct7[5]);
        end else begin
          dec_new.alu_op = alu_base(funct3, 1'b0);
        end
      end
      OPC_OP: begin
        fmt = FMT_R; wb_req = 1'b1;
        if (funct7 == F7_BASE) begin
          dec_new.alu_op = alu_base(funct3, 1'b0);
        end else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
          dec_new.alu_op = alu_base(funct3, 1'b1);
        end else if (funct7 == F7_MEXT) begin
`ifdef CPU_RV32M_EN
          dec_new.alu_op = ALU_MUL | {2'b00, funct3};
`else
          legal = 1'b0;
`endif
        end else begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase

    dec_new.imm = imm_gen(bus.f_instr, fmt);
    dec_new.rd  = fmt_has_rd(fmt) ? rd_idx : 5'd0;

    if (!legal) begin
      wb_req              = 1'b0;
      dec_new.alu_op      = ALU_ADD;
      dec_new.alu_src_imm = 1'b0;
      dec_new.is_load     = 1'b0;
      dec_new.is_store    = 1'b0;
      dec_new.is_branch   = 1'b0;
      dec_new.is_jal      = 1'b0;
      dec_new.is_jalr     = 1'b0;
      dec_new.illegal     = 1'b1;
    end
    dec_new.wb_en = wb_req && (dec_new.rd != 5'd0);
  end

  assign uses_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
  assign uses_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};

  assign stall = dec_q.valid && dec_q.is_load && (dec_q.rd != 5'd0) &&
                 bus.i_otp_rdy && !bus.e_j_flag &&
                 ((uses_rs1 && (rs1_idx == dec_q.rd)) || (uses_rs2 && (rs2_idx == dec_q.rd)));

  assign accept = bus.i_otp_rdy && bus.d_inp_rdy && !stall && !bus.e_j_flag;

  // Flush outranks hold; a bubble keeps stale data fields but no control
  always_comb begin
    dec_d = dec_q;
    if (bus.e_j_flag || (bus.d_inp_rdy && !accept)) begin
      dec_d.valid       = 1'b0;
      dec_d.alu_src_imm = 1'b0;
      dec_d.wb_en       = 1'b0;
      dec_d.is_load     = 1'b0;
      dec_d.is_store    = 1'b0;
      dec_d.is_branch   = 1'b0;
      dec_d.is_jal      = 1'b0;
      dec_d.is_jalr     = 1'b0;
      dec_d.illegal     = 1'b0;
    end else if (accept) begin
      dec_d = dec_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign bus.d_stall       = stall;
  assign bus.d_otp_rdy     = dec_q.valid;
  assign bus.d_pc          = dec_q.pc;
  assign bus.d_rs1_val     = dec_q.rs1_val;
  assign bus.d_rs2_val     = dec_q.rs2_val;
  assign bus.d_imm         = dec_q.imm;
  assign bus.d_rd          = dec_q.rd;
  assign bus.d_funct3      = dec_q.funct3;
  assign bus.d_alu_op      = dec_q.alu_op;
  assign bus.d_alu_src_imm = dec_q.alu_src_imm;
  assign bus.d_wb_en       = dec_q.wb_en;
  assign bus.d_is_load     = dec_q.is_load;
  assign bus.d_is_store    = dec_q.is_store;
  assign bus.d_is_branch   = dec_q.is_branch;
  assign bus.d_is_jal      = dec_q.is_jal;
  assign bus.d_is_jalr     = dec_q.is_jalr;
  assign bus.d_illegal     = dec_q.illegal;

endmodule

`default_nettype wire

// File: doc/cpu_idecode.md
# cpu_idecode

Decode stage of the basic RV32 pipeline. It consumes the fetch stage's `i_otp_rdy`/`f_instr`/`f_pc` output and registers a fully decoded instruction for execute: operands read from the register file, sign-extended immediate, and control fields. It detects load-use hazards and back-pressures fetch with `d_stall`. It drops in-flight work when execute redirects with `e_j_flag`.

## Interface
- No parameters; XLEN fixed at 32.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_otp_rdy` in 1: fetch output valid.
- `f_instr` in 32: instruction word from fetch.
- `f_pc` in 32: PC of `f_instr`.
- `e_j_flag` in 1: execute redirect; flushes decode.
- `d_inp_rdy` in 1: downstream advance enable. Low means hold all outputs.
- `w_en` in 1: write-back enable.
- `w_rd` in 5: write-back destination register.
- `w_data` in 32: write-back data.
- `d_stall` out 1: combinational; fetch must hold `f_instr`/`f_pc` while it is high.
- `d_otp_rdy` out 1: decoded instruction valid.
- `d_pc` out 32, `d_rs1_val` out 32, `d_rs2_val` out 32, `d_imm` out 32.
- `d_rd` out 5, `d_funct3` out 3, `d_alu_op` out 5.
- `d_alu_src_imm`, `d_wb_en`, `d_is_load`, `d_is_store`, `d_is_branch`, `d_is_jal`, `d_is_jalr`, `d_illegal`: each out 1.

## Operation
- **Accept:** `i_otp_rdy && d_inp_rdy && !d_stall && !e_j_flag`. The D register loads the decoded fields and sets `d_otp_rdy`=1.
- **Bubble:** `d_inp_rdy && !accept`. `d_otp_rdy` is set to 0 and the control flags are cleared. Data fields are don't-care.
- **Hold:** `!d_inp_rdy`. All D outputs keep their values, including `d_otp_rdy`.
- **Flush:** `e_j_flag` takes priority over hold and stall. It forces `d_otp_rdy`=0 on the next edge.
- **Hazard:** `d_stall` = `d_otp_rdy && d_is_load && d_rd!=0 && i_otp_rdy && (rs1 match || rs2 match)`.
  - A source is only checked if the incoming format uses it: R/S/B formats use rs1 and rs2; I-format and JALR use rs1 only.
  - `d_stall` is 0 while `e_j_flag` is high.
- **Immediates:** I, S, B, U and J formats, each sign-extended to 32 bits. B and J immediates have LSB 0.
- **Supported opcodes:** LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode sets `d_illegal`=1 and `d_wb_en`=0, and gives `d_otp_rdy`=1 so execute can trap.
  - For OP/OP-IMM, an unsupported funct7 value is also illegal.
- **Register file:** 32×32, two asynchronous read ports, one write port.
  - x0 reads 0; writes to x0 are ignored.
  - Write-through bypass: if `w_en && w_rd==rsN && rsN!=0`, the read returns `w_data`.
- **`d_wb_en`:** 1 for LUI, AUIPC, JAL, JALR, LOAD, OP and OP-IMM, and only when `d_rd!=0`.

## Timing
- Decode latency is 1 cycle: an instruction accepted at edge N is visible on the D outputs after edge N.
- A register-file write at edge N is visible to combinational reads after edge N, and to the same-cycle decode through the bypass.
- **Reset:** `d_otp_rdy`=0, all flags 0, `d_pc`/`d_rs1_val`/`d_rs2_val`/`d_imm`=0, `d_rd`/`d_funct3`/`d_alu_op`=0, register file all zeros. Reset mid-stall releases `d_stall` on the next cycle.
- **Simultaneous events:**
  - `e_j_flag` with `w_en`: the write still commits.
  - Stall with `!d_inp_rdy`: hold.
  - Stall with flush: flush.

## Configuration
- `CPU_RV32M_EN` defined: OP with funct7=0000001 decodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU to distinct `d_alu_op` codes.
- `CPU_RV32M_EN` undefined: those encodings set `d_illegal`=1.

## Structure
- Package `cpu_pkg` holds:
  - Opcode constants (`OPC_*`).
  - `d_alu_op` encodings (`ALU_ADD`, `ALU_SUB`, …, `ALU_MUL`…). RV32I codes lie in 0–15 and M codes in 16–23.
  - Immediate format enum.
- One sub-module, `cpu_regfile`, containing the array, reset clear, and the bypass logic.

## Test plan
- Reset, then `f_instr`=0x00500093 (ADDI x1,x0,5) with `i_otp_rdy`=1 and `d_inp_rdy`=1. Next cycle: `d_otp_rdy`=1, `d_rd`=1, `d_imm`=5, `d_alu_op`=ALU_ADD, `d_alu_src_imm`=1, `d_wb_en`=1, `d_rs1_val`=0.
- `w_en`=1, `w_rd`=1, `w_data`=0x1234 in the same cycle as an instruction reading x1. Required: `d_rs1_val`=0x1234. A write with `w_rd`=0 leaves x0 reading 0.
- 0x0000A103 (LW x2,0(x1)) followed by 0x002101B3 (ADD x3,x2,x2). Required:
  - `d_stall`=1 for exactly 1 cycle, and a bubble with `d_otp_rdy`=0.
  - The ADD then issues with `d_rd`=3.
- `e_j_flag`=1 while a valid instruction is presented. Required: `d_otp_rdy`=0 next cycle and `d_stall`=0.
- `d_inp_rdy`=0 for 3 cycles while `f_instr` changes. Required: D outputs unchanged.
- 0x022081B3 (MUL x3,x1,x2). With `CPU_RV32M_EN`: `d_alu_op`=ALU_MUL and `d_illegal`=0. Without it: `d_illegal`=1 and `d_wb_en`=0. Separately, `f_instr`=0xFFFFFFFF gives `d_illegal`=1.
